// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared encodings for the branch program-counter block
//
// Purpose: branch_mode encodings and the fixed instruction size, shared by
// branch_pc and its testbench.
// Ports: none (package).

package branch_pkg;

    // Bytes per instruction; the sequential step and the link value use it.
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        MODE_SEQ   = 3'd0,
        MODE_B     = 3'd1,
        MODE_CBZ   = 3'd2,
        MODE_CBNZ  = 3'd3,
        MODE_BCOND = 3'd4,
        MODE_BL    = 3'd5,
        MODE_BR    = 3'd6,
        MODE_RET   = 3'd7
    } branch_mode_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular LIFO return-address stack
//
// Purpose: return-address stack. A push when full overwrites the oldest
// entry, so the most recent DEPTH return addresses are always kept.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   push, pop      - one operation per cycle; push wins if both are set
//   push_data      - value written on push
//   pop_data       - current top of stack (valid when !empty)
//   full, empty    - occupancy flags
//   count          - number of valid entries, saturating at DEPTH

module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_ptr;

    // r_wr_ptr is the next free slot; the top entry sits just below it.
    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign w_top_ptr = r_wr_ptr - PTR_W'(1);
    assign pop_data  = r_mem[w_top_ptr];
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;

    // Entry contents need no reset; only the pointer and count define validity.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (push) begin
            // When full, r_wr_ptr already points at the oldest entry, which
            // this push overwrites; the count stays saturated.
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_pc.sv
// rtl/branch_pc.sv - fetch-address generator with branches and return stack
//
// Purpose: computes the next fetch address each cycle from branch_mode,
// flags, a signed word offset and a register target, with a return-address
// stack for BL/RET. All outputs are registered.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   stall             - hold all state this cycle (reset has priority)
//   branch_mode       - SEQ/B/CBZ/CBNZ/BCOND/BL/BR/RET
//   zero_flag         - tested by CBZ/CBNZ
//   cond_true         - tested by BCOND
//   offset            - signed word offset
//   reg_target        - target for BR and for RET on an empty stack
//   read_address      - current fetch address
//   scaled_offset     - offset << OFFSET_SHIFT, sign-extended
//   link_address      - return address written by the last BL
//   taken             - last update left the sequential path
//   ras_count         - valid return-stack entries
//   ras_overflow      - sticky, a BL overwrote a stack entry
//   ras_underflow     - one-cycle pulse, RET with empty stack

module branch_pc
    import branch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    OFFSET_SHIFT = 2,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   branch_mode,
    input  logic                         zero_flag,
    input  logic                         cond_true,
    input  logic [31:0]                  offset,
    input  logic [ADDR_WIDTH-1:0]        reg_target,
    output logic [ADDR_WIDTH-1:0]        read_address,
    output logic [ADDR_WIDTH-1:0]        scaled_offset,
    output logic [ADDR_WIDTH-1:0]        link_address,
    output logic                         taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    logic [ADDR_WIDTH-1:0] r_read_address;
    logic [ADDR_WIDTH-1:0] r_scaled_offset;
    logic [ADDR_WIDTH-1:0] r_link_address;
    logic                  r_taken;
    logic                  r_ras_overflow;
    logic                  r_ras_underflow;

    branch_mode_e          w_mode;
    logic [ADDR_WIDTH-1:0] w_off_ext;
    logic [ADDR_WIDTH-1:0] w_scaled;
    logic [ADDR_WIDTH-1:0] w_seq;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_underflow;
    logic                  w_stack_push;
    logic                  w_stack_pop;
    logic [ADDR_WIDTH-1:0] w_pop_data;
    logic                  w_full;
    logic                  w_empty;

    assign w_mode    = branch_mode_e'(branch_mode);
    // Sized cast of a signed value sign-extends (or truncates) to the address width.
    assign w_off_ext = ADDR_WIDTH'($signed(offset));
    assign w_scaled  = w_off_ext << OFFSET_SHIFT;
    assign w_seq     = r_read_address + ADDR_WIDTH'(INSTR_BYTES);
    assign w_tgt     = r_read_address + w_scaled;

    always_comb begin
        w_next      = w_seq;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        case (w_mode)
            MODE_SEQ:   w_next = w_seq;
            MODE_B:     w_next = w_tgt;
            MODE_CBZ:   w_next = zero_flag ? w_tgt : w_seq;
            MODE_CBNZ:  w_next = zero_flag ? w_seq : w_tgt;
            MODE_BCOND: w_next = cond_true ? w_tgt : w_seq;
            MODE_BL: begin
                w_next = w_tgt;
                w_push = 1'b1;
            end
            MODE_BR:    w_next = reg_target;
            MODE_RET: begin
                if (w_empty) begin
                    w_next      = reg_target;
                    w_underflow = 1'b1;
                end else begin
                    w_next = w_pop_data;
                    w_pop  = 1'b1;
                end
            end
            default:    w_next = w_seq;
        endcase
    end

    // Stack operations are dropped while stalled or in reset.
    assign w_stack_push = w_push && !stall && !reset;
    assign w_stack_pop  = w_pop && !stall && !reset;

    ras_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (w_stack_push),
        .pop       (w_stack_pop),
        .push_data (w_seq),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (ras_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_address  <= RESET_VECTOR;
            r_scaled_offset <= '0;
            r_link_address  <= '0;
            r_taken         <= 1'b0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
        end else if (stall) begin
            // Everything holds; the underflow pulse must not repeat.
            r_ras_underflow <= 1'b0;
        end else begin
            r_read_address  <= w_next;
            r_scaled_offset <= w_scaled;
            // A branch whose target equals the sequential address is not "taken".
            r_taken         <= (w_next != w_seq);
            r_ras_underflow <= w_underflow;
            if (w_push) begin
                r_link_address <= w_seq;
                if (w_full) begin
                    r_ras_overflow <= 1'b1;
                end
            end
        end
    end

    assign read_address  = r_read_address;
    assign scaled_offset = r_scaled_offset;
    assign link_address  = r_link_address;
    assign taken         = r_taken;
    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;

endmodule

// File: tb/tb_branch_pc.sv
// tb/tb_branch_pc.sv - directed self-checking bench for branch_pc

module tb_branch_pc;
    import branch_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic [2:0]  branch_mode;
    logic        zero_flag;
    logic        cond_true;
    logic [31:0] offset;
    logic [31:0] reg_target;
    logic [31:0] read_address;
    logic [31:0] scaled_offset;
    logic [31:0] link_address;
    logic        taken;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    branch_pc u_dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_mode   (branch_mode),
        .zero_flag     (zero_flag),
        .cond_true     (cond_true),
        .offset        (offset),
        .reg_target    (reg_target),
        .read_address  (read_address),
        .scaled_offset (scaled_offset),
        .link_address  (link_address),
        .taken         (taken),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic step(input logic [2:0] m, input logic [31:0] off, input logic [31:0] rt,
                        input logic z, input logic c);
        branch_mode = m;
        offset      = off;
        reg_target  = rt;
        zero_flag   = z;
        cond_true   = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        branch_mode = MODE_SEQ;
        zero_flag = 1'b0;
        cond_true = 1'b0;
        offset = 32'd0;
        reg_target = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_addr", read_address, 32'h0);
        check("rst_scaled", scaled_offset, 32'h0);
        check("rst_link", link_address, 32'h0);
        check("rst_taken", taken, 1'b0);
        check("rst_count", ras_count, 3'd0);
        check("rst_ovf", ras_overflow, 1'b0);
        check("rst_unf", ras_underflow, 1'b0);
        reset = 1'b0;

        // Sequential run
        step(MODE_SEQ, 0, 0, 0, 0); check("seq1", read_address, 32'h4);
        step(MODE_SEQ, 0, 0, 0, 0); check("seq2", read_address, 32'h8);
        step(MODE_SEQ, 0, 0, 0, 0); check("seq3", read_address, 32'hC);
        check("seq_taken", taken, 1'b0);

        // Conditional branches from 0x100
        step(MODE_BR, 0, 32'h100, 0, 0);
        check("br100", read_address, 32'h100);
        check("br100_taken", taken, 1'b1);
        step(MODE_CBZ, 32'hFFFF_FFFE, 0, 1, 0);
        check("cbz_addr", read_address, 32'hF8);
        check("cbz_taken", taken, 1'b1);
        check("cbz_scaled", scaled_offset, 32'hFFFF_FFF8);
        step(MODE_CBNZ, 32'hFFFF_FFFE, 0, 1, 0);
        check("cbnz_addr", read_address, 32'hFC);
        check("cbnz_taken", taken, 1'b0);
        step(MODE_BCOND, 32'd4, 0, 0, 1);
        check("bcond_addr", read_address, 32'h10C);
        check("bcond_taken", taken, 1'b1);

        // Call and return
        step(MODE_BR, 0, 32'h40, 0, 0);
        step(MODE_BL, 32'd16, 0, 0, 0);
        check("bl_addr", read_address, 32'h80);
        check("bl_link", link_address, 32'h44);
        check("bl_count", ras_count, 3'd1);
        step(MODE_RET, 0, 32'hDEAD_0000, 0, 0);
        check("ret_addr", read_address, 32'h44);
        check("ret_count", ras_count, 3'd0);
        check("ret_unf", ras_underflow, 1'b0);

        // Overflow: five BLs (+16 bytes each) from 0x44
        step(MODE_BL, 32'd4, 0, 0, 0); check("ovf_bl1", read_address, 32'h54);
        step(MODE_BL, 32'd4, 0, 0, 0);
        step(MODE_BL, 32'd4, 0, 0, 0);
        step(MODE_BL, 32'd4, 0, 0, 0);
        check("ovf_cnt4", ras_count, 3'd4);
        check("ovf_flag4", ras_overflow, 1'b0);
        step(MODE_BL, 32'd4, 0, 0, 0);
        check("ovf_addr5", read_address, 32'h94);
        check("ovf_link5", link_address, 32'h88);
        check("ovf_cnt5", ras_count, 3'd4);
        check("ovf_flag5", ras_overflow, 1'b1);
        step(MODE_RET, 0, 0, 0, 0); check("pop1", read_address, 32'h88); check("pop1_cnt", ras_count, 3'd3);
        step(MODE_RET, 0, 0, 0, 0); check("pop2", read_address, 32'h78); check("pop2_cnt", ras_count, 3'd2);
        step(MODE_RET, 0, 0, 0, 0); check("pop3", read_address, 32'h68); check("pop3_cnt", ras_count, 3'd1);
        step(MODE_RET, 0, 0, 0, 0); check("pop4", read_address, 32'h58); check("pop4_cnt", ras_count, 3'd0);
        check("pop4_unf", ras_underflow, 1'b0);

        // Underflow then BR
        step(MODE_RET, 0, 32'h200, 0, 0);
        check("unf_addr", read_address, 32'h200);
        check("unf_pulse", ras_underflow, 1'b1);
        check("unf_count", ras_count, 3'd0);
        check("ovf_sticky", ras_overflow, 1'b1);
        step(MODE_BR, 0, 32'h300, 0, 0);
        check("br300", read_address, 32'h300);
        check("unf_clear", ras_underflow, 1'b0);

        // Stall holds everything
        stall = 1'b1;
        step(MODE_B, 32'd8, 0, 0, 0);
        check("stall1_addr", read_address, 32'h300);
        step(MODE_B, 32'd8, 0, 0, 0);
        check("stall2_addr", read_address, 32'h300);
        check("stall_scaled", scaled_offset, 32'h0);
        step(MODE_BL, 32'd8, 0, 0, 0);
        check("stall_bl_cnt", ras_count, 3'd0);
        check("stall_bl_link", link_address, 32'h88);
        step(MODE_RET, 0, 32'h500, 0, 0);
        check("stall_ret_addr", read_address, 32'h300);
        check("stall_ret_unf", ras_underflow, 1'b0);

        // Reset wins over stall
        reset = 1'b1;
        step(MODE_B, 32'd8, 0, 0, 0);
        check("rststall_addr", read_address, 32'h0);
        check("rststall_ovf", ras_overflow, 1'b0);
        check("rststall_link", link_address, 32'h0);
        reset = 1'b0;
        stall = 1'b0;

        // Address wrap
        step(MODE_BR, 0, 32'hFFFF_FFFC, 0, 0);
        check("wrap_pre", read_address, 32'hFFFF_FFFC);
        step(MODE_SEQ, 0, 0, 0, 0);
        check("wrap_addr", read_address, 32'h0);
        check("wrap_taken", taken, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_pc.md
BRANCH_PC -- requirements
Module: branch_pc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of every address output and of reg_target.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: value of read_address after reset.
REQ-003 SHALL have parameter OFFSET_SHIFT, default 2: left-shift applied to the word offset.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-008 SHALL have port branch_mode, input, 3 bits: 0 SEQ, 1 B, 2 CBZ, 3 CBNZ, 4 BCOND, 5 BL, 6 BR, 7 RET.
REQ-009 SHALL have port zero_flag, input, 1 bit: tested by CBZ and CBNZ.
REQ-010 SHALL have port cond_true, input, 1 bit: pre-evaluated condition, tested by BCOND.
REQ-011 SHALL have port offset, input, 32 bits: signed word offset.
REQ-012 SHALL have port reg_target, input, ADDR_WIDTH bits: register target for BR and for the RET fallback.
REQ-013 SHALL have port read_address, output, ADDR_WIDTH bits: current fetch address (registered).
REQ-014 SHALL have port scaled_offset, output, ADDR_WIDTH bits: registered offset << OFFSET_SHIFT.
REQ-015 SHALL have port link_address, output, ADDR_WIDTH bits: registered return address written by the last BL.
REQ-016 SHALL have port taken, output, 1 bit: registered; 1 when the last update was a non-sequential step.
REQ-017 SHALL have port ras_count, output, clog2(RAS_DEPTH)+1 bits: number of valid stack entries.
REQ-018 SHALL have port ras_overflow, output, 1 bit: sticky flag, set when a BL overwrites an entry.
REQ-019 SHALL have port ras_underflow, output, 1 bit: one-cycle pulse on a RET with an empty stack.

Function
REQ-020 SHALL compute seq = read_address + 4 and tgt = read_address + (sign-extended offset << OFFSET_SHIFT), each truncated mod 2^ADDR_WIDTH.
REQ-021 SHALL, on each non-stalled edge, update read_address as follows: SEQ gives seq; B gives tgt; CBZ gives tgt if zero_flag else seq; CBNZ gives tgt if !zero_flag else seq; BCOND gives tgt if cond_true else seq.
REQ-022 SHALL, for BL, load tgt into read_address, load seq into link_address and push seq onto the stack.
REQ-023 SHALL, for BR, load reg_target into read_address.
REQ-024 SHALL, for RET with ras_count > 0, pop the top entry into read_address and decrement ras_count.
REQ-025 SHALL, for RET with an empty stack, load reg_target into read_address, keep ras_count at 0 and pulse ras_underflow.
REQ-026 SHALL update scaled_offset every non-stalled cycle, regardless of mode.
REQ-027 SHALL set taken to 1 when the new read_address differs from the seq path selection, and to 0 otherwise.
REQ-028 SHALL implement the stack as circular, LIFO order. A push when full overwrites the oldest entry, ras_count saturates at RAS_DEPTH and ras_overflow is set. A subsequent pop still returns the most recent entry.
REQ-029 SHALL hold every register, including the stack, taken and ras_underflow (forced to 0), while stall=1.
REQ-030 SHALL give all outputs a latency of one cycle from the inputs and SHALL have no combinational input-to-output path.

Reset
REQ-031 SHALL give reset priority over stall.
REQ-032 SHALL, on reset, set read_address=RESET_VECTOR; scaled_offset=0; link_address=0; taken=0; ras_count=0; ras_overflow=0; ras_underflow=0.
REQ-033 SHALL leave stack entry contents don't-care after reset; reset during a push or pop discards that operation.

Structure
REQ-034 SHALL place the branch_mode encodings and the instruction size (4) in the shared package branch_pkg.
REQ-035 SHALL use one sub-module, ras_stack: a circular LIFO with push, pop, full, empty and count.

Verification
REQ-036 SHALL cover sequential run: reset, then 3 SEQ cycles -> read_address 0, 4, 8, 12; taken=0.
REQ-037 SHALL cover conditional branches: at 0x100, CBZ offset=-2 with zero_flag=1 -> 0xF8, taken=1. Then CBNZ with zero_flag=1 -> 0xFC, taken=0.
REQ-038 SHALL cover call and return: at 0x40, BL offset=16 -> read_address 0x80, link_address 0x44, ras_count 1. Then RET -> 0x44, ras_count 0.
REQ-039 SHALL cover overflow: 5 BLs with RAS_DEPTH=4 -> ras_count 4, ras_overflow=1. Then 4 RETs return the last four links in reverse order.
REQ-040 SHALL cover underflow and BR: RET on an empty stack with reg_target=0x200 -> 0x200 and a 1-cycle ras_underflow pulse. Then BR with reg_target=0x300 -> 0x300.
REQ-041 SHALL cover stall/reset interaction: stall=1 with B held for 2 cycles -> no change. Then reset and stall together -> RESET_VECTOR. Also check wrap: from 0xFFFFFFFC, SEQ -> 0.
